// File: rtl/io_pkg.sv
// Shared constants for the I/O port responder: data width, register offsets
// and STATUS/CTRL bit positions.
package io_pkg;

    localparam int DW = 8;

    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_RELOAD = 4'h2;
    localparam logic [3:0] OFF_CTRL   = 4'h3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_TFLAG = 2;
    localparam int ST_OVF   = 3;

    localparam int CTRL_EN = 0;

    function automatic logic [DW-1:0] status_byte(input logic ovf, input logic tflag,
                                                  input logic full, input logic empty);
        logic [DW-1:0] s;
        s = '0;
        s[ST_OVF]   = ovf;
        s[ST_TFLAG] = tflag;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is not reset; empty/count gate anything read out of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: 16-byte register window with an output FIFO
// and an 8-bit reloading down-counter that drives irq.
module io_port_responder
    import io_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR  = 15'h7F00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [14:0]   addr,
    input  logic [DW-1:0] wdata,
    input  logic          rd_en,
    input  logic          wr_en,
    output logic [DW-1:0] rdata,
    output logic          hit,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    off;
    logic          sel_wr;
    logic          sel_rd;
    logic          data_wr;
    logic          status_wr;
    logic          reload_wr;
    logic          ctrl_wr;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [CW-1:0] fifo_count;

    logic          ovf;
    logic          tflag;
    logic          ctrl_en;
    logic [DW-1:0] reload;
    logic [DW-1:0] cnt;
    logic          expire;
    logic          ovf_set;
    logic [DW-1:0] rd_mux;

    assign off    = addr[3:0];
    assign hit    = (addr[14:4] == BASE_ADDR[14:4]);
    // A write wins over a simultaneous read.
    assign sel_wr = hit && wr_en;
    assign sel_rd = hit && rd_en && !wr_en;

    assign data_wr   = sel_wr && (off == OFF_DATA);
    assign status_wr = sel_wr && (off == OFF_STATUS);
    assign reload_wr = sel_wr && (off == OFF_RELOAD);
    assign ctrl_wr   = sel_wr && (off == OFF_CTRL);

    // Drain side is valid/ready: out_data is the head whenever out_valid is
    // high, and an entry leaves on any cycle where out_valid and out_ready
    // are both high; out_valid never depends on out_ready.
    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;
    assign ovf_set   = data_wr && fifo_full && !fifo_pop;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr),
        .pop   (fifo_pop),
        .wdata (wdata),
        .head  (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A RELOAD write pre-empts both the decrement and the expiry this cycle.
    assign expire = ctrl_en && (cnt == '0) && !reload_wr;
    assign irq    = tflag;

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_DATA:   rd_mux = DW'(fifo_count);
            OFF_STATUS: rd_mux = status_byte(ovf, tflag, fifo_full, fifo_empty);
            OFF_RELOAD: rd_mux = reload;
            OFF_CTRL:   rd_mux = {{(DW-1){1'b0}}, ctrl_en};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata   <= '0;
            ovf     <= 1'b0;
            tflag   <= 1'b0;
            ctrl_en <= 1'b0;
            reload  <= '0;
            cnt     <= '0;
        end else begin
            rdata <= sel_rd ? rd_mux : '0;

            if (reload_wr) begin
                reload <= wdata;
                cnt    <= wdata;
            end else if (ctrl_en) begin
                cnt <= expire ? reload : cnt - 8'd1;
            end

            if (ctrl_wr) ctrl_en <= wdata[CTRL_EN];

            // Setting beats clearing when both land in the same cycle.
            tflag <= expire  || (tflag && !(status_wr && wdata[ST_TFLAG]));
            ovf   <= ovf_set || (ovf   && !(status_wr && wdata[ST_OVF]));
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: register-map vector table, FIFO scoreboard
// and hand-written timer/overflow/reset sequences.
module tb_io_port_responder;

    localparam logic [14:0] BASE  = 15'h7F00;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  rdata;
    logic        hit;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;

    io_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .rdata     (rdata),
        .hit       (hit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle: score the drain side and model any DATA push, then
    // cross the edge and return 1 time unit after it.
    task automatic tick();
        logic       popping;
        logic [7:0] h;
        #1;
        check("out_valid", 8'(out_valid), 8'(exp_q.size() != 0));
        popping = out_ready && (exp_q.size() != 0);
        if (popping) begin
            h = exp_q.pop_front();
            check("out_data", out_data, h);
        end
        if ((addr[14:4] == BASE[14:4]) && wr_en && (addr[3:0] == 4'h0)) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(wdata);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [3:0] off, input logic r, input logic w,
                          input logic [7:0] d);
        addr  = BASE | {11'd0, off};
        rd_en = r;
        wr_en = w;
        wdata = d;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] off, input logic [7:0] exp);
        access(off, 1'b1, 1'b0, 8'h00);
        check(name, rdata, exp);
    endtask

    typedef struct {
        logic [14:0] a;
        logic        r;
        logic        w;
        logic [7:0]  d;
        logic        exp_hit;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Reset values
        rst = 1'b1;
        #3;
        check("rst_out_valid", 8'(out_valid), 8'h00);
        check("rst_irq", 8'(irq), 8'h00);
        check("rst_rdata", rdata, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Register map vectors
        vecs[0]  = '{BASE | 15'h1, 1, 0, 8'h00, 1, 8'h01};
        vecs[1]  = '{BASE | 15'h0, 1, 0, 8'h00, 1, 8'h00};
        vecs[2]  = '{BASE | 15'h2, 1, 0, 8'h00, 1, 8'h00};
        vecs[3]  = '{BASE | 15'h3, 1, 0, 8'h00, 1, 8'h00};
        vecs[4]  = '{BASE | 15'h2, 0, 1, 8'hA5, 1, 8'h00};
        vecs[5]  = '{BASE | 15'h2, 1, 0, 8'h00, 1, 8'hA5};
        vecs[6]  = '{BASE | 15'h4, 1, 0, 8'h00, 1, 8'h00};
        vecs[7]  = '{BASE | 15'h7, 0, 1, 8'hFF, 1, 8'h00};
        vecs[8]  = '{BASE | 15'h7, 1, 0, 8'h00, 1, 8'h00};
        vecs[9]  = '{BASE | 15'hF, 1, 0, 8'h00, 1, 8'h00};
        vecs[10] = '{BASE + 15'h10, 1, 0, 8'h00, 0, 8'h00};
        vecs[11] = '{15'h7EF2, 1, 0, 8'h00, 0, 8'h00};
        vecs[12] = '{BASE | 15'h2, 0, 1, 8'h00, 1, 8'h00};
        vecs[13] = '{BASE | 15'h1, 1, 0, 8'h00, 1, 8'h01};
        for (int i = 0; i < 14; i++) begin
            addr  = vecs[i].a;
            rd_en = vecs[i].r;
            wr_en = vecs[i].w;
            wdata = vecs[i].d;
            #1;
            check($sformatf("vec%0d_hit", i), 8'(hit), 8'(vecs[i].exp_hit));
            tick();
            rd_en = 1'b0;
            wr_en = 1'b0;
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
        end
        tick();
        check("idle_rdata", rdata, 8'h00);

        // Three pushes held back, count read, then drain in order
        out_ready = 1'b0;
        access(4'h0, 0, 1, 8'h11);
        access(4'h0, 0, 1, 8'h22);
        access(4'h0, 0, 1, 8'h33);
        rd_chk("count3", 4'h0, 8'h03);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("drained_valid", 8'(out_valid), 8'h00);

        // Overflow: five writes into a four-deep FIFO
        for (int i = 0; i < 5; i++) access(4'h0, 0, 1, 8'($urandom_range(0, 255)));
        check("model_ovf", 8'(m_ovf), 8'h01);
        rd_chk("status_ovf_full", 4'h1, 8'h0A);
        access(4'h1, 0, 1, 8'h08);
        rd_chk("status_ovf_clr", 4'h1, 8'h02);

        // Push while full with a simultaneous pop
        out_ready = 1'b1;
        access(4'h0, 0, 1, 8'h55);
        out_ready = 1'b0;
        rd_chk("count_full_pushpop", 4'h0, 8'h04);
        rd_chk("status_no_ovf", 4'h1, 8'h02);
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        rd_chk("status_empty", 4'h1, 8'h01);

        // Out-of-window read and read+write collision
        addr = BASE + 15'h10;
        rd_en = 1'b1;
        #1;
        check("miss_hit", 8'(hit), 8'h00);
        tick();
        rd_en = 1'b0;
        check("miss_rdata", rdata, 8'h00);
        access(4'h0, 1, 1, 8'h77);
        check("rdwr_rdata", rdata, 8'h00);
        rd_chk("rdwr_count", 4'h0, 8'h01);
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;

        // Timer: enable first, then RELOAD=3 -> tflag every 4 cycles
        access(4'h3, 0, 1, 8'h01);
        access(4'h2, 0, 1, 8'h03);
        check("irq_e0", 8'(irq), 8'h00);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("irq_e%0d", k), 8'(irq), 8'h00);
        end
        tick();
        check("irq_e4", 8'(irq), 8'h01);
        rd_chk("status_tflag", 4'h1, 8'h05);
        check("irq_e5_clr", 8'(irq), 8'h01);
        access(4'h1, 0, 1, 8'h04);
        check("irq_e6_cleared", 8'(irq), 8'h00);
        tick();
        check("irq_e7", 8'(irq), 8'h00);
        tick();
        check("irq_e8", 8'(irq), 8'h01);
        repeat (3) tick();
        access(4'h1, 0, 1, 8'h04);
        check("irq_set_beats_clr", 8'(irq), 8'h01);
        access(4'h1, 0, 1, 8'h04);
        check("irq_clr_after", 8'(irq), 8'h00);

        // RELOAD=0 expires every cycle, so a clear never sticks
        access(4'h2, 0, 1, 8'h00);
        tick();
        check("irq_reload0", 8'(irq), 8'h01);
        access(4'h1, 0, 1, 8'h04);
        check("irq_reload0_clr", 8'(irq), 8'h01);

        // Disabled timer holds: no expiry after clearing
        access(4'h2, 0, 1, 8'h02);
        access(4'h3, 0, 1, 8'h00);
        access(4'h1, 0, 1, 8'h04);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("irq_disabled", 8'(irq), 8'h00);
        end

        // Reset with two queued entries and the timer running
        access(4'h0, 0, 1, 8'hC1);
        access(4'h0, 0, 1, 8'hC2);
        access(4'h3, 0, 1, 8'h01);
        access(4'h2, 0, 1, 8'h00);
        tick();
        check("pre_rst_irq", 8'(irq), 8'h01);
        addr  = BASE | 15'h1;
        rd_en = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 8'(out_valid), 8'h00);
        check("mid_rst_irq", 8'(irq), 8'h00);
        check("mid_rst_rdata", rdata, 8'h00);
        rd_en = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_chk("post_rst_status", 4'h1, 8'h01);
        rd_chk("post_rst_count", 4'h0, 8'h00);
        check("post_rst_irq", 8'(irq), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
